// File: rtl/alu_seq_pkg.sv
// Shared encodings for the multi-word ALU sequencer and its nbitALU slice.
// The op values double as nbitALU mode values.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_INC = 3'b110,
        OP_DEC = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_arith(op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC) || (op == OP_DEC);
    endfunction

endpackage

// File: rtl/alu_multiword_seq_if.sv
// Requester-side start/done bus of the multi-word ALU sequencer.
interface alu_multiword_seq_if #(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
);
    logic                   start;
    logic [2:0]             op;
    logic [WIDTH*WORDS-1:0] opa;
    logic [WIDTH*WORDS-1:0] opb;
    logic                   busy;
    logic                   done;
    logic [WIDTH*WORDS-1:0] result;
    logic                   carry_out;
    logic                   zero;

    modport master (
        output start, op, opa, opb,
        input  busy, done, result, carry_out, zero
    );

    modport slave (
        input  start, op, opa, opb,
        output busy, done, result, carry_out, zero
    );
endinterface

// File: rtl/alu_multiword_seq_alu.sv
// nbitALU: single WIDTH-bit combinational ALU slice.
// Logic modes report carry_out = 0.
module nbitALU
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] y,
    output logic             carry_out
);

    always_comb begin
        y         = '0;
        carry_out = 1'b0;
        case (op_e'(mode))
            OP_ADD: {carry_out, y} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
            OP_SUB: {carry_out, y} = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, carry_in};
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOT: y = ~a;
            OP_INC: {carry_out, y} = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
            OP_DEC: {carry_out, y} = {1'b0, a} + {1'b0, {WIDTH{1'b1}}};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_multiword_seq.sv
// Multi-word ALU sequencer: runs one nbitALU slice once per word, LSW first,
// chaining the carry through a register between words.
module alu_multiword_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_multiword_seq_if.slave bus
);

    localparam int TOTAL = WIDTH * WORDS;
    localparam int IDX_W = $clog2(WORDS);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    op_e                op_q;
    logic [TOTAL-1:0]   a_q, b_q, result_q;
    logic               carry_out_q, zero_q;

    logic               accept, last_word;
    logic [TOTAL-1:0]   b_mapped;
    logic               carry_init;
    logic [2:0]         slice_mode;
    logic [WIDTH-1:0]   slice_a, slice_b, slice_y;
    logic               slice_cout;
    logic [TOTAL-1:0]   result_next;

    assign accept    = bus.start && (state_q != RUN);
    assign last_word = (idx_q == IDX_W'(WORDS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last_word) state_d = DONE;
            DONE:    state_d = accept ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Arithmetic ops all become ADD with a pre-mapped B and a preset carry,
    // so the mapping is applied once when the request is captured.
    always_comb begin
        b_mapped   = bus.opb;
        carry_init = 1'b0;
        case (op_e'(bus.op))
            OP_SUB: begin b_mapped = ~bus.opb; carry_init = 1'b1; end
            OP_INC: begin b_mapped = '0;       carry_init = 1'b1; end
            OP_DEC: begin b_mapped = '1;       carry_init = 1'b0; end
            default: ;
        endcase
    end

    always_comb begin
        slice_mode  = is_arith(op_q) ? 3'(OP_ADD) : 3'(op_q);
        slice_a     = a_q[int'(idx_q)*WIDTH +: WIDTH];
        slice_b     = b_q[int'(idx_q)*WIDTH +: WIDTH];
        result_next = result_q;
        result_next[int'(idx_q)*WIDTH +: WIDTH] = slice_y;
    end

    nbitALU #(.WIDTH(WIDTH)) u_slice (
        .mode      (slice_mode),
        .a         (slice_a),
        .b         (slice_b),
        .carry_in  (carry_q),
        .y         (slice_y),
        .carry_out (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            zero_q      <= 1'b0;
        end else if (accept) begin
            op_q     <= op_e'(bus.op);
            a_q      <= bus.opa;
            b_q      <= b_mapped;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= carry_init;
        end else if (state_q == RUN) begin
            result_q <= result_next;
            carry_q  <= slice_cout;
            idx_q    <= idx_q + IDX_W'(1);
            if (last_word) begin
                carry_out_q <= is_arith(op_q) & slice_cout;
                zero_q      <= (result_next == '0);
            end
        end
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.carry_out = carry_out_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu_multiword_seq.sv
// Self-checking bench for alu_multiword_seq (WIDTH=4, WORDS=4) against a
// 16-bit arithmetic reference model.
module tb_alu_multiword_seq;

    localparam int WIDTH = 4;
    localparam int WORDS = 4;

    localparam logic [2:0] C_ADD = 3'd0, C_SUB = 3'd1, C_AND = 3'd2, C_OR = 3'd3,
                           C_XOR = 3'd4, C_NOT = 3'd5, C_INC = 3'd6, C_DEC = 3'd7;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_multiword_seq_if #(.WIDTH(WIDTH), .WORDS(WORDS)) bus ();

    alu_multiword_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Reference: plain 16-bit unsigned arithmetic.
    function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic c);
        logic [16:0] w;
        c = 1'b0;
        r = '0;
        case (op)
            C_ADD: begin w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16]; end
            C_SUB: begin r = a - b; c = (a >= b); end
            C_AND: r = a & b;
            C_OR:  r = a | b;
            C_XOR: r = a ^ b;
            C_NOT: r = ~a;
            C_INC: begin w = {1'b0, a} + 17'd1; r = w[15:0]; c = w[16]; end
            C_DEC: begin r = a - 16'd1; c = (a != 16'd0); end
            default: ;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] r, output logic c, output logic z,
                          output int lat, output int bcnt, output bit ovl);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.opa   = a;
        bus.opb   = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat  = 0;
        bcnt = 0;
        ovl  = 1'b0;
        while (bus.done !== 1'b1 && lat < 20) begin
            if (bus.busy === 1'b1) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (bus.busy === 1'b1 && bus.done === 1'b1) ovl = 1'b1;
        r = bus.result;
        c = bus.carry_out;
        z = bus.zero;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.opa   = '0;
        bus.opb   = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.result !== 16'h0000) begin errors++; $display("[TB] FAIL reset_result got=%h exp=0000", bus.result); end
        checks++; if (bus.carry_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_carry got=%b exp=0", bus.carry_out); end
        checks++; if (bus.zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_zero got=%b exp=0", bus.zero); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        logic [15:0] r; logic c, z; int lat, bcnt; bit ovl;
        run_op(C_ADD, 16'h00FF, 16'h0001, r, c, z, lat, bcnt, ovl);
        checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL latency got=%0d exp=4", lat); end
        checks++; if (bcnt !== 4) begin errors++; $display("[TB] FAIL busy_cycles got=%0d exp=4", bcnt); end
        checks++; if (ovl !== 1'b0) begin errors++; $display("[TB] FAIL busy_done_overlap got=%b exp=0", ovl); end
        checks++; if (r !== 16'h0100) begin errors++; $display("[TB] FAIL ripple_result got=%h exp=0100", r); end
        checks++; if (c !== 1'b0 || z !== 1'b0) begin errors++; $display("[TB] FAIL ripple_flags got c=%b z=%b exp c=0 z=0", c, z); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_done got busy=%b done=%b exp 0 0", bus.busy, bus.done); end
        checks++; if (bus.result !== 16'h0100) begin errors++; $display("[TB] FAIL result_hold got=%h exp=0100", bus.result); end
    endtask

    task automatic test_directed();
        logic [2:0]  t_op [10] = '{C_ADD, C_SUB, C_SUB, C_INC, C_DEC, C_DEC, C_XOR, C_NOT, C_AND, C_ADD};
        logic [15:0] t_a  [10] = '{16'hFFFF, 16'h1000, 16'h0001, 16'hFFFF, 16'h0000, 16'h1000, 16'hF0F0, 16'h1234, 16'hFFFF, 16'h1234};
        logic [15:0] t_b  [10] = '{16'h0001, 16'h0001, 16'h0002, 16'hA5A5, 16'h5A5A, 16'hA5A5, 16'hFF00, 16'hA5A5, 16'h0000, 16'h4321};
        logic [15:0] t_r  [10] = '{16'h0000, 16'h0FFF, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0FFF, 16'h0FF0, 16'hEDCB, 16'h0000, 16'h5555};
        logic        t_c  [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        t_z  [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] r; logic c, z; int lat, bcnt; bit ovl;
        for (int i = 0; i < 10; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], r, c, z, lat, bcnt, ovl);
            checks++; if (r !== t_r[i]) begin errors++; $display("[TB] FAIL directed_result[%0d] got=%h exp=%h", i, r, t_r[i]); end
            checks++; if (c !== t_c[i]) begin errors++; $display("[TB] FAIL directed_carry[%0d] got=%b exp=%b", i, c, t_c[i]); end
            checks++; if (z !== t_z[i]) begin errors++; $display("[TB] FAIL directed_zero[%0d] got=%b exp=%b", i, z, t_z[i]); end
        end
    endtask

    task automatic test_start_while_busy();
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.op = C_ADD; bus.opa = 16'h1111; bus.opb = 16'h2222;
        @(posedge clk);
        #1;
        bus.op = C_SUB; bus.opa = 16'hFFFF; bus.opb = 16'h0001;
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 2;
        while (bus.done !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL busy_start_latency got=%0d exp=4", lat); end
        checks++; if (bus.result !== 16'h3333) begin errors++; $display("[TB] FAIL busy_start_result got=%h exp=3333", bus.result); end
        checks++; if (bus.carry_out !== 1'b0) begin errors++; $display("[TB] FAIL busy_start_carry got=%b exp=0", bus.carry_out); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] r; logic c, z; int lat, bcnt; bit ovl;
        run_op(C_ADD, 16'h0001, 16'h0002, r, c, z, lat, bcnt, ovl);
        checks++; if (r !== 16'h0003) begin errors++; $display("[TB] FAIL b2b_first got=%h exp=0003", r); end
        bus.start = 1'b1; bus.op = C_SUB; bus.opa = 16'h0005; bus.opb = 16'h0003;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_accept got busy=%b done=%b exp 1 0", bus.busy, bus.done); end
        lat = 0;
        while (bus.done !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL b2b_latency got=%0d exp=4", lat); end
        checks++; if (bus.result !== 16'h0002 || bus.carry_out !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second got=%h c=%b exp=0002 c=1", bus.result, bus.carry_out); end
    endtask

    task automatic test_reset_mid_op();
        logic [15:0] r; logic c, z; int lat, bcnt; bit ovl; bit saw_done;
        run_op(C_INC, 16'hFFFF, 16'h0000, r, c, z, lat, bcnt, ovl);
        @(negedge clk);
        bus.start = 1'b1; bus.op = C_ADD; bus.opa = 16'h1234; bus.opb = 16'h1111;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_ctrl got busy=%b done=%b exp 0 0", bus.busy, bus.done); end
        checks++; if (bus.result !== 16'h0000) begin errors++; $display("[TB] FAIL midreset_result got=%h exp=0000", bus.result); end
        checks++; if (bus.carry_out !== 1'b0 || bus.zero !== 1'b0) begin errors++; $display("[TB] FAIL midreset_flags got c=%b z=%b exp 0 0", bus.carry_out, bus.zero); end
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (8) begin @(posedge clk); #1; if (bus.done === 1'b1) saw_done = 1'b1; end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_no_done got=%b exp=0", saw_done); end
    endtask

    task automatic test_random();
        logic [15:0] r, a, b, er; logic c, z, ec; logic [2:0] op; int lat, bcnt; bit ovl;
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = 16'($urandom);
            b  = 16'($urandom);
            if (i % 7 == 0) a = 16'h0000;
            run_op(op, a, b, r, c, z, lat, bcnt, ovl);
            model(op, a, b, er, ec);
            checks++; if (r !== er) begin errors++; $display("[TB] FAIL rand_result op=%0d a=%h b=%h got=%h exp=%h", op, a, b, r, er); end
            checks++; if (c !== ec) begin errors++; $display("[TB] FAIL rand_carry op=%0d a=%h b=%h got=%b exp=%b", op, a, b, c, ec); end
            checks++; if (z !== (er == 16'h0000)) begin errors++; $display("[TB] FAIL rand_zero op=%0d got=%b exp=%b", op, z, (er == 16'h0000)); end
            checks++; if (lat !== 4 || ovl !== 1'b0) begin errors++; $display("[TB] FAIL rand_timing got lat=%0d ovl=%b exp lat=4 ovl=0", lat, ovl); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
